l2_set_reader: RTL and testbench

//  Upstream stage of the L2 lookup. Accepts a set-read request and issues the tag/state SRAM read.

---
 rtl/l2_set_reader.sv | 201 ++++++++++++++++++++
 tb/tb_l2_set_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_set_reader.sv
// l2_set_reader: upstream stage of the L2 lookup.
// Accepts a set-read request, strobes the tag/state SRAM, waits out the SRAM
// latency and then holds tags, states and the eviction way for the lookup
// stage until a lookup_en pulse consumes them. Also owns the per-set
// round-robin eviction pointers.
// Optional feature: define L2_SET_READER_FWD_EN to add a write port whose
// writes to the in-flight set are merged into the buffers.
module l2_set_reader #(
    parameter int L2_WAYS        = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int L2_SETS        = 256,
    parameter int TAG_BITS       = 20,
    parameter int STATE_BITS     = 3,
    parameter int SRAM_LAT       = 1,
    localparam int SET_BITS      = $clog2(L2_SETS),
    localparam int WAY_BITS      = $clog2(L2_WAYS),
    localparam int LINE_ST_BITS  = WORDS_PER_LINE * STATE_BITS,
    localparam int TAGV_BITS     = L2_WAYS * TAG_BITS,
    localparam int STV_BITS      = L2_WAYS * LINE_ST_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [SET_BITS-1:0]  rd_req_set,
    output logic                 sram_rd_en,
    output logic [SET_BITS-1:0]  sram_rd_set,
    input  logic [TAGV_BITS-1:0] sram_tags_q,
    input  logic [STV_BITS-1:0]  sram_states_q,
    output logic                 bufs_valid,
    input  logic                 lookup_en,
    output logic [TAGV_BITS-1:0] tags_buf,
    output logic [STV_BITS-1:0]  states_buf,
    output logic [WAY_BITS-1:0]  evict_way_buf,
    input  logic                 evict_adv,
    input  logic [SET_BITS-1:0]  evict_adv_set
`ifdef L2_SET_READER_FWD_EN
    ,
    input  logic                    wr_en,
    input  logic [SET_BITS-1:0]     wr_set,
    input  logic [WAY_BITS-1:0]     wr_way,
    input  logic [TAG_BITS-1:0]     wr_tag,
    input  logic [LINE_ST_BITS-1:0] wr_states
`endif
);

    localparam int CNT_BITS = $clog2(SRAM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [SET_BITS-1:0]  set_q;
    logic                 accept;
    logic                 capture;
    logic [WAY_BITS-1:0]  evict_ptr [L2_SETS];
    logic                 adv_hit;
    logic [WAY_BITS-1:0]  ptr_for_buf;
    logic [TAGV_BITS-1:0] cap_tags;
    logic [STV_BITS-1:0]  cap_states;

    // Next state, latency countdown and request handshake; nothing is
    // accepted while reset is held so every output reads 0 in reset
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_req_ready = 1'b0;
        sram_rd_en   = 1'b0;
        sram_rd_set  = '0;
        accept       = 1'b0;
        capture      = 1'b0;
        case (state_q)
            IDLE: rd_req_ready = 1'b1;
            RD: begin
                cnt_d = cnt_q - CNT_BITS'(1);
                if (cnt_d == '0) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                rd_req_ready = lookup_en;
                if (lookup_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst) rd_req_ready = 1'b0;
        accept = rd_req_valid & rd_req_ready;
        if (accept) begin
            sram_rd_en  = 1'b1;
            sram_rd_set = rd_req_set;
            state_d     = RD;
            cnt_d       = CNT_BITS'(SRAM_LAT);
        end
    end

    // FSM state and latency counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-set round-robin eviction pointer; natural wrap since ways is a power of 2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < L2_SETS; i++) evict_ptr[i] <= '0;
        end else if (evict_adv) begin
            evict_ptr[evict_adv_set] <= evict_ptr[evict_adv_set] + WAY_BITS'(1);
        end
    end

    assign adv_hit     = evict_adv && (evict_adv_set == set_q);
    assign ptr_for_buf = adv_hit ? evict_ptr[set_q] + WAY_BITS'(1) : evict_ptr[set_q];

`ifdef L2_SET_READER_FWD_EN
    logic                 wr_hit;
    logic [L2_WAYS-1:0]   pend_q;
    logic [TAGV_BITS-1:0] merged_tags;
    logic [STV_BITS-1:0]  merged_states;

    assign wr_hit = wr_en && (wr_set == set_q) && (state_q == RD || state_q == HOLD);

    // Buffer contents with this cycle's write to the latched set folded in
    always_comb begin
        merged_tags   = tags_buf;
        merged_states = states_buf;
        if (wr_hit) begin
            merged_tags[wr_way*TAG_BITS +: TAG_BITS]           = wr_tag;
            merged_states[wr_way*LINE_ST_BITS +: LINE_ST_BITS] = wr_states;
        end
    end

    // Capture data: SRAM output except for ways written since the read began
    always_comb begin
        cap_tags   = sram_tags_q;
        cap_states = sram_states_q;
        for (int w = 0; w < L2_WAYS; w++) begin
            if (pend_q[w] || (wr_hit && wr_way == WAY_BITS'(w))) begin
                cap_tags[w*TAG_BITS +: TAG_BITS]           = merged_tags[w*TAG_BITS +: TAG_BITS];
                cap_states[w*LINE_ST_BITS +: LINE_ST_BITS] = merged_states[w*LINE_ST_BITS +: LINE_ST_BITS];
            end
        end
    end

    // Remember which ways were written while the SRAM read is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else if (accept) begin
            pend_q <= '0;
        end else if (wr_hit && state_q == RD) begin
            pend_q[wr_way] <= 1'b1;
        end
    end
`else
    assign cap_tags   = sram_tags_q;
    assign cap_states = sram_states_q;
`endif

    // Latched set, output buffers and their valid flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_q         <= '0;
            bufs_valid    <= 1'b0;
            tags_buf      <= '0;
            states_buf    <= '0;
            evict_way_buf <= '0;
        end else begin
            if (accept) begin
                set_q      <= rd_req_set;
                bufs_valid <= 1'b0;
            end else if (state_q == HOLD && lookup_en) begin
                bufs_valid <= 1'b0;
            end
            if (capture) begin
                tags_buf      <= cap_tags;
                states_buf    <= cap_states;
                evict_way_buf <= ptr_for_buf;
                bufs_valid    <= 1'b1;
            end else begin
                if (state_q == HOLD && adv_hit) evict_way_buf <= ptr_for_buf;
`ifdef L2_SET_READER_FWD_EN
                if (wr_hit) begin
                    tags_buf   <= merged_tags;
                    states_buf <= merged_states;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_l2_set_reader.sv
// tb_l2_set_reader: self-checking bench for l2_set_reader (default build).
// Directed scenarios followed by randomized reads, with a reference model of
// the per-set eviction pointers and of which SRAM word each read captures.
module tb_l2_set_reader;

    localparam int L2_WAYS    = 8;
    localparam int WORDS      = 4;
    localparam int L2_SETS    = 256;
    localparam int TAG_BITS   = 20;
    localparam int STATE_BITS = 3;
    localparam int LAT        = 1;
    localparam int SET_BITS   = 8;
    localparam int WAY_BITS   = 3;
    localparam int TAGV       = L2_WAYS * TAG_BITS;
    localparam int STV        = L2_WAYS * WORDS * STATE_BITS;

    logic                clk = 1'b0;
    logic                rst;
    logic                rd_req_valid;
    logic                rd_req_ready;
    logic [SET_BITS-1:0] rd_req_set;
    logic                sram_rd_en;
    logic [SET_BITS-1:0] sram_rd_set;
    logic [TAGV-1:0]     sram_tags_q;
    logic [STV-1:0]      sram_states_q;
    logic                bufs_valid;
    logic                lookup_en;
    logic [TAGV-1:0]     tags_buf;
    logic [STV-1:0]      states_buf;
    logic [WAY_BITS-1:0] evict_way_buf;
    logic                evict_adv;
    logic [SET_BITS-1:0] evict_adv_set;

    int              asserts_evaluated = 0;
    int              failures = 0;
    int              ptr_m [L2_SETS];
    logic [TAGV-1:0] exp_tags;
    logic [STV-1:0]  exp_states;
    int              cur_set;
    bit              rand_adv = 1'b0;

    l2_set_reader #(
        .L2_WAYS(L2_WAYS), .WORDS_PER_LINE(WORDS), .L2_SETS(L2_SETS),
        .TAG_BITS(TAG_BITS), .STATE_BITS(STATE_BITS), .SRAM_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_set(rd_req_set),
        .sram_rd_en(sram_rd_en), .sram_rd_set(sram_rd_set),
        .sram_tags_q(sram_tags_q), .sram_states_q(sram_states_q),
        .bufs_valid(bufs_valid), .lookup_en(lookup_en),
        .tags_buf(tags_buf), .states_buf(states_buf), .evict_way_buf(evict_way_buf),
        .evict_adv(evict_adv), .evict_adv_set(evict_adv_set)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        asserts_evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit valid, input int set, input bit lookup,
                                 input bit adv, input int adv_set);
        rd_req_valid  = valid;
        rd_req_set    = SET_BITS'(set);
        lookup_en     = lookup;
        evict_adv     = adv;
        evict_adv_set = SET_BITS'(adv_set);
    endtask

    task automatic randomizeSram();
        for (int w = 0; w < L2_WAYS; w++)
            sram_tags_q[w*TAG_BITS +: TAG_BITS] = TAG_BITS'($urandom);
        for (int i = 0; i < L2_WAYS*WORDS; i++)
            sram_states_q[i*STATE_BITS +: STATE_BITS] = STATE_BITS'($urandom);
    endtask

    // One clock edge; the pointer model advances by what was driven into it
    task automatic tick();
        bit adv  = evict_adv;
        int aset = int'(evict_adv_set);
        @(posedge clk);
        if (adv) ptr_m[aset] = (ptr_m[aset] + 1) % L2_WAYS;
        #1;
    endtask

    // Issue a read of one set, then follow it through to the buffered result
    task automatic readSet(input int set, input bit with_lookup, input bit adv_cap,
                           input bit force3, input logic [TAG_BITS-1:0] tag3);
        applyStimulus(1'b1, set, with_lookup, 1'b0, 0);
        if (rand_adv) begin
            evict_adv     = 1'($urandom_range(1, 0));
            evict_adv_set = SET_BITS'($urandom_range(3, 0));
        end
        randomizeSram();
        #1;
        checkOutput("req_ready", rd_req_ready, 1);
        checkOutput("req_rd_en", sram_rd_en, 1);
        checkOutput("req_rd_set", sram_rd_set, set);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 0);
        checkOutput("valid_low_in_rd", bufs_valid, 0);
        for (int k = 1; k <= LAT; k++) begin
            randomizeSram();
            lookup_en = 1'($urandom_range(1, 0));
            if (rand_adv) begin
                evict_adv     = 1'($urandom_range(1, 0));
                evict_adv_set = SET_BITS'($urandom_range(3, 0));
            end
            if (k == LAT) begin
                if (force3) sram_tags_q[3*TAG_BITS +: TAG_BITS] = tag3;
                if (adv_cap) begin
                    evict_adv     = 1'b1;
                    evict_adv_set = SET_BITS'(set);
                end
                exp_tags   = sram_tags_q;
                exp_states = sram_states_q;
            end
            #1;
            checkOutput("rd_strobe_once", sram_rd_en, 0);
            checkOutput("rd_not_ready", rd_req_ready, 0);
            tick();
            applyStimulus(1'b0, 0, 1'b0, 1'b0, 0);
        end
        cur_set = set;
        checkOutput("valid_up", bufs_valid, 1);
        checkOutput("cap_tags", tags_buf, exp_tags);
        checkOutput("cap_states", states_buf, exp_states);
        checkOutput("cap_evict", evict_way_buf, ptr_m[set]);
    endtask

    // Stay in HOLD while the SRAM output churns and pointers may advance
    task automatic holdCycles(input int n, input bit adv_rand);
        for (int i = 0; i < n; i++) begin
            randomizeSram();
            applyStimulus(1'($urandom_range(1, 0)), $urandom_range(15, 0), 1'b0, 1'b0, 0);
            if (adv_rand) begin
                evict_adv     = 1'($urandom_range(1, 0));
                evict_adv_set = SET_BITS'($urandom_range(3, 0));
            end
            #1;
            checkOutput("hold_not_ready", rd_req_ready, 0);
            checkOutput("hold_no_strobe", sram_rd_en, 0);
            tick();
            applyStimulus(1'b0, 0, 1'b0, 1'b0, 0);
            checkOutput("hold_valid", bufs_valid, 1);
            checkOutput("hold_tags", tags_buf, exp_tags);
            checkOutput("hold_states", states_buf, exp_states);
            checkOutput("hold_evict", evict_way_buf, ptr_m[cur_set]);
        end
    endtask

    // Consume the buffers without a follow-up request
    task automatic releaseBufs();
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 0);
        #1;
        checkOutput("release_ready", rd_req_ready, 1);
        tick();
        lookup_en = 1'b0;
        checkOutput("release_valid", bufs_valid, 0);
        checkOutput("idle_ready", rd_req_ready, 1);
    endtask

    // Directed scenarios, then randomized traffic, then reset mid-read
    initial begin
        for (int i = 0; i < L2_SETS; i++) ptr_m[i] = 0;
        rst = 1'b0;
        applyStimulus(1'b1, 3, 1'b0, 1'b0, 0);
        sram_tags_q   = '0;
        sram_states_q = '0;
        tick();
        tick();
        checkOutput("rst_valid", bufs_valid, 0);
        checkOutput("rst_ready", rd_req_ready, 0);
        checkOutput("rst_rd_en", sram_rd_en, 0);
        checkOutput("rst_tags", tags_buf, 0);
        checkOutput("rst_states", states_buf, 0);
        checkOutput("rst_evict", evict_way_buf, 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 0);
        rst = 1'b1;
        tick();

        $display("[TB] read of set 5 with way 3 tag abcde");
        readSet(5, 1'b0, 1'b0, 1'b1, 20'hABCDE);
        checkOutput("t1_way3_tag", tags_buf[3*TAG_BITS +: TAG_BITS], 20'hABCDE);

        $display("[TB] hold 10 cycles with toggling sram data");
        holdCycles(10, 1'b0);

        $display("[TB] back-to-back read of set 6");
        readSet(6, 1'b1, 1'b0, 1'b0, '0);
        releaseBufs();

        $display("[TB] eviction pointer of set 2");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b1, 2);
            tick();
        end
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 0);
        readSet(2, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("t4_evict_after_9", evict_way_buf, 1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 2);
        tick();
        evict_adv = 1'b0;
        checkOutput("t4_evict_hold_adv", evict_way_buf, 2);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 3);
        tick();
        evict_adv = 1'b0;
        checkOutput("t4_evict_other_set", evict_way_buf, 2);
        releaseBufs();
        readSet(7, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t4_evict_capture_adv", evict_way_buf, 1);
        holdCycles(3, 1'b1);

        $display("[TB] randomized reads");
        rand_adv = 1'b1;
        for (int it = 0; it < 30; it++) begin
            int s;
            s = $urandom_range(3, 0);
            if ($urandom_range(1, 0) == 1) begin
                readSet(s, 1'b1, 1'($urandom_range(1, 0)), 1'b0, '0);
            end else begin
                releaseBufs();
                readSet(s, 1'b0, 1'($urandom_range(1, 0)), 1'b0, '0);
            end
            holdCycles($urandom_range(3, 0), 1'b1);
        end
        rand_adv = 1'b0;

        $display("[TB] reset during RD");
        releaseBufs();
        applyStimulus(1'b1, 9, 1'b0, 1'b1, 4);
        randomizeSram();
        tick();
        applyStimulus(1'b1, 9, 1'b0, 1'b0, 0);
        rst = 1'b0;
        #1;
        checkOutput("t5_valid", bufs_valid, 0);
        checkOutput("t5_tags", tags_buf, 0);
        checkOutput("t5_states", states_buf, 0);
        checkOutput("t5_evict", evict_way_buf, 0);
        checkOutput("t5_ready", rd_req_ready, 0);
        checkOutput("t5_rd_en", sram_rd_en, 0);
        checkOutput("t5_rd_set", sram_rd_set, 0);
        for (int i = 0; i < L2_SETS; i++) ptr_m[i] = 0;
        tick();
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomizeSram();
            tick();
            checkOutput("t5_stale_ignored", bufs_valid, 0);
        end
        readSet(4, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("t5_ptr_cleared", evict_way_buf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_evaluated, failures);
        $finish;
    end

endmodule
